// File: rtl/insn_mem_fetch_pkg.sv
// Shared constants and types for the instruction memory fetch block.
// Covers the NOP fill word, the response fault codes and the sequencer states.
package insn_mem_fetch_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   localparam logic [1:0] FAULT_OK       = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

   // A misaligned PC is reported even when it is also out of range.
   function automatic logic [1:0] fault_code(input logic misalign, input logic out_of_range);
      if (misalign)
         return FAULT_MISALIGN;
      else if (out_of_range)
         return FAULT_RANGE;
      else
         return FAULT_OK;
   endfunction

endpackage

// File: rtl/insn_mem_fetch_if.sv
// Fetch request/response handshake and program-load port of the instruction memory.
// The fetch stage and loader use the master side; the memory uses the slave side.
interface insn_mem_fetch_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 10
);
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_pc;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_insn;
   logic [XLEN-1:0] rsp_pc;
   logic [1:0]      rsp_fault;
   logic            ld_we;
   logic [AW-1:0]   ld_addr;
   logic [XLEN-1:0] ld_data;

   modport master (
      output req_valid, req_pc, rsp_ready, ld_we, ld_addr, ld_data,
      input  req_ready, rsp_valid, rsp_insn, rsp_pc, rsp_fault
   );

   modport slave (
      input  req_valid, req_pc, rsp_ready, ld_we, ld_addr, ld_data,
      output req_ready, rsp_valid, rsp_insn, rsp_pc, rsp_fault
   );

endinterface

// File: rtl/insn_mem_fetch_sram.sv
// Single-port synchronous word array with a registered read port.
// Read data only changes on a read, so it stays stable while a response is held.
module insn_mem_fetch_sram #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/insn_mem_fetch.sv
// Instruction memory with power-up NOP fill, valid/ready fetch port and program-load port.
// Misaligned and out-of-range PCs return a fault code instead of aliasing into the array.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_INIT | filling word fill_q with INIT_WORD, fetch and load blocked
//   ST_RUN  | serving fetches; a load write takes the array port
module insn_mem_fetch
   import insn_mem_fetch_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     DEPTH     = 1024,
   parameter logic [XLEN-1:0] INIT_WORD = NOP_WORD,
   parameter bit              CLEAR_EN  = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   insn_mem_fetch_if.slave bus,
   output logic            busy
);

   localparam int unsigned  AW        = $clog2(DEPTH);
   localparam logic [AW:0]  FILL_LAST = (AW+1)'(DEPTH - 1);
   localparam fetch_state_e RST_STATE = CLEAR_EN ? ST_INIT : ST_RUN;

   fetch_state_e    state_q, state_d;
   logic [AW:0]     fill_q, fill_d;

   logic            mem_we;
   logic            mem_re;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;

   logic            req_ready;
   logic            accept;
   logic            pc_misalign;
   logic            pc_range;
   logic [1:0]      req_fault;

   logic            rsp_valid_q;
   logic [XLEN-1:0] rsp_pc_q;
   logic [1:0]      rsp_fault_q;

   assign pc_misalign = |bus.req_pc[1:0];
   assign pc_range    = |bus.req_pc[XLEN-1:AW+2];
   assign req_fault   = fault_code(pc_misalign, pc_range);

   // A load write owns the array port, so a fetch in the same cycle waits.
   assign req_ready = !rst && (state_q == ST_RUN) && !bus.ld_we &&
                      (!rsp_valid_q || bus.rsp_ready);
   assign accept    = bus.req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_STATE;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = INIT_WORD;
      unique case (state_q)
         ST_INIT: begin
            mem_we   = 1'b1;
            mem_addr = fill_q[AW-1:0];
            fill_d   = fill_q + 1'b1;
            if (fill_q == FILL_LAST)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.ld_we) begin
               mem_we    = 1'b1;
               mem_addr  = bus.ld_addr;
               mem_wdata = bus.ld_data;
            end else if (accept && (req_fault == FAULT_OK)) begin
               mem_re   = 1'b1;
               mem_addr = bus.req_pc[AW+1:2];
            end
         end
      endcase
   end

   insn_mem_fetch_sram #(
      .W     (XLEN),
      .DEPTH (DEPTH)
   ) u_sram (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_pc_q    <= '0;
         rsp_fault_q <= FAULT_OK;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_pc_q    <= bus.req_pc;
         rsp_fault_q <= req_fault;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_pc    = rsp_pc_q;
   assign bus.rsp_fault = rsp_fault_q;
   assign bus.rsp_insn  = (rsp_fault_q != FAULT_OK) ? INIT_WORD : mem_rdata;
   assign busy          = (state_q == ST_INIT);

endmodule

// File: tb/tb_insn_mem_fetch.sv
// Self-checking bench for insn_mem_fetch (DEPTH=16): fill timing, loads, faults,
// backpressure, load/fetch port contention and reset during fill.
module tb_insn_mem_fetch;
   import insn_mem_fetch_pkg::*;

   localparam int          DEPTH = 16;
   localparam int          AW    = 4;
   localparam int          NVEC  = 10;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [1:0]  fault;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t exp_q[$];
   int   rsp_cyc_q[$];
   exp_t vec[NVEC];

   insn_mem_fetch_if #(.XLEN(32), .AW(AW)) bus ();

   insn_mem_fetch #(
      .XLEN      (32),
      .DEPTH     (DEPTH),
      .INIT_WORD (NOP),
      .CLEAR_EN  (1'b1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every completed response handshake pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
         rsp_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected_pc", bus.rsp_pc, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_insn",  bus.rsp_insn, e.insn);
            chk("rsp_pc",    bus.rsp_pc, e.pc);
            chk("rsp_fault", 32'(bus.rsp_fault), 32'(e.fault));
         end
      end
   end

   // Entered and left just after a rising edge; req_valid is left asserted.
   task automatic issue(input logic [31:0] pc, input logic [31:0] insn, input logic [1:0] fault);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_pc    = pc;
      do begin
         @(negedge clk);
         n++;
      end while (bus.req_ready !== 1'b1 && n < 40);
      if (bus.req_ready !== 1'b1)
         chk("issue_timeout_ready", 32'(bus.req_ready), 32'd1);
      else
         exp_q.push_back('{pc: pc, insn: insn, fault: fault});
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] addr, input logic [31:0] data);
      bus.ld_we   = 1'b1;
      bus.ld_addr = addr;
      bus.ld_data = data;
      @(posedge clk);
      #1;
      bus.ld_we = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic count_busy(input string name);
      int n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
      end
      chk(name, 32'(n), 32'(DEPTH));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{pc: 32'h0000_0000, insn: 32'h0010_80B3, fault: FAULT_OK};
      vec[1] = '{pc: 32'h0000_0004, insn: 32'h0011_0133, fault: FAULT_OK};
      vec[2] = '{pc: 32'h0000_0008, insn: 32'h0011_81B3, fault: FAULT_OK};
      vec[3] = '{pc: 32'h0000_000C, insn: 32'h0012_7233, fault: FAULT_OK};
      vec[4] = '{pc: 32'h0000_0006, insn: NOP,           fault: FAULT_MISALIGN};
      vec[5] = '{pc: 32'h0000_0040, insn: NOP,           fault: FAULT_RANGE};
      vec[6] = '{pc: 32'h0000_0042, insn: NOP,           fault: FAULT_MISALIGN};
      vec[7] = '{pc: 32'h0000_003C, insn: NOP,           fault: FAULT_OK};
      vec[8] = '{pc: 32'hFFFF_FFFC, insn: NOP,           fault: FAULT_RANGE};
      vec[9] = '{pc: 32'h0000_0010, insn: NOP,           fault: FAULT_OK};

      bus.req_valid = 1'b0;
      bus.req_pc    = '0;
      bus.rsp_ready = 1'b1;
      bus.ld_we     = 1'b0;
      bus.ld_addr   = '0;
      bus.ld_data   = '0;

      // Reset values and fill length
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_insn",  bus.rsp_insn, 32'd0);
      chk("rst_rsp_pc",    bus.rsp_pc, 32'd0);
      chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
      chk("rst_busy",      32'(busy), 32'd1);
      rst = 1'b0;
      count_busy("init_cycles");
      issue(32'h20, NOP, FAULT_OK);
      bus.req_valid = 1'b0;
      drain();

      // Program load, then the vector table issued back-to-back
      load(4'd0, 32'h0010_80B3);
      load(4'd1, 32'h0011_0133);
      load(4'd2, 32'h0011_81B3);
      load(4'd3, 32'h0012_7233);
      rsp_cyc_q.delete();
      for (int i = 0; i < NVEC; i++)
         issue(vec[i].pc, vec[i].insn, vec[i].fault);
      bus.req_valid = 1'b0;
      drain();
      chk("b2b_count", 32'(rsp_cyc_q.size()), 32'(NVEC));
      if (rsp_cyc_q.size() == NVEC)
         chk("b2b_span", 32'(rsp_cyc_q[NVEC-1] - rsp_cyc_q[0]), 32'(NVEC - 1));

      // Backpressure: response held for three cycles, released into a same-cycle accept
      bus.rsp_ready = 1'b0;
      issue(32'h8, 32'h0011_81B3, FAULT_OK);
      bus.req_pc = 32'hC;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_rsp_insn",  bus.rsp_insn, 32'h0011_81B3);
         chk("bp_rsp_pc",    bus.rsp_pc, 32'h8);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
      if (bus.req_ready === 1'b1)
         exp_q.push_back('{pc: 32'hC, insn: 32'h0012_7233, fault: FAULT_OK});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      drain();

      // Load and fetch in the same cycle: load wins, fetch then sees the new word
      bus.ld_we     = 1'b1;
      bus.ld_addr   = 4'd2;
      bus.ld_data   = 32'hDEAD_BEEF;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h8;
      @(negedge clk);
      chk("ld_blocks_req", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.ld_we = 1'b0;
      issue(32'h8, 32'hDEAD_BEEF, FAULT_OK);
      bus.req_valid = 1'b0;
      drain();

      // Reset in RUN drops a held response; reset at fill index 7 restarts the fill
      bus.rsp_ready = 1'b0;
      issue(32'h0, 32'h0010_80B3, FAULT_OK);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_run_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      exp_q.delete();
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_init_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_init_rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      count_busy("refill_cycles");
      issue(32'h8, NOP, FAULT_OK);
      issue(32'h0, NOP, FAULT_OK);
      bus.req_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
